// File: rtl/sr_car_queue_counter.sv
// sr_car_queue_counter: debounced secondary-road car arrival counter that
// produces the waiting-car count (MR_cars) consumed by the traffic light
// controller. Arrivals come from a glitchy loop sensor, departures are timed
// from the secondary-road green phase, and the count saturates at MAX_CARS.
module sr_car_queue_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DEPART_CYCLES   = 2,
    parameter int unsigned MAX_CARS        = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arrive_raw,
    input  logic [1:0] SR_ctl,
    input  logic       clr,
    output logic [7:0] MR_cars,
    output logic       arrive_pulse,
    output logic       overflow
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEP_W-1:0] DEP_LAST = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [7:0]       CAR_MAX  = 8'(MAX_CARS);
    localparam logic [1:0]       SR_GREEN = 2'b11;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        HIGH         = 2'd2,
        CONFIRM_LOW  = 2'd3
    } db_state_t;

    logic             r_s1;
    logic             r_s2;
    db_state_t        r_db_state;
    logic [DB_W-1:0]  r_db_cnt;
    logic [DEP_W-1:0] r_dep_cnt;
    logic [7:0]       r_cars;
    logic             r_pulse;
    logic             r_ovf;

    logic             w_arrive;
    logic             w_depart;
    logic             w_green;

    // Arrival fires on the sample that completes the high confirmation window
    assign w_arrive = (r_db_state == CONFIRM_HIGH) && r_s2 && (r_db_cnt == DB_LAST);
    assign w_green  = (SR_ctl == SR_GREEN);
    // Departure fires when the green timer wraps, but only if a car is waiting
    assign w_depart = w_green && (r_dep_cnt == DEP_LAST) && (r_cars != 8'd0);

    // Two-flop synchronizer for the asynchronous loop sensor
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= arrive_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM: a level change is accepted only after it persists
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_state <= IDLE_LOW;
            r_db_cnt   <= '0;
        end else begin
            case (r_db_state)
                IDLE_LOW: begin
                    if (r_s2) begin
                        r_db_state <= CONFIRM_HIGH;
                        r_db_cnt   <= '0;
                    end
                end
                CONFIRM_HIGH: begin
                    if (!r_s2) begin
                        r_db_state <= IDLE_LOW;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state <= HIGH;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!r_s2) begin
                        r_db_state <= CONFIRM_LOW;
                        r_db_cnt   <= '0;
                    end
                end
                CONFIRM_LOW: begin
                    if (r_s2) begin
                        r_db_state <= HIGH;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state <= IDLE_LOW;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_db_state <= IDLE_LOW;
                    r_db_cnt   <= '0;
                end
            endcase
        end
    end

    // Departure timer: counts green cycles, restarts whenever green ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dep_cnt <= '0;
        end else if (!w_green) begin
            r_dep_cnt <= '0;
        end else if (r_dep_cnt == DEP_LAST) begin
            r_dep_cnt <= '0;
        end else begin
            r_dep_cnt <= r_dep_cnt + 1'b1;
        end
    end

    // Count update: clear, then net-zero, then saturating arrival, then departure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cars  <= '0;
            r_pulse <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_pulse <= w_arrive;
            if (clr) begin
                r_cars <= '0;
                r_ovf  <= 1'b0;
            end else if (w_arrive && w_depart) begin
                r_cars <= r_cars;
            end else if (w_arrive) begin
                if (r_cars < CAR_MAX) begin
                    r_cars <= r_cars + 8'd1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_depart) begin
                r_cars <= r_cars - 8'd1;
            end
        end
    end

    assign MR_cars      = r_cars;
    assign arrive_pulse = r_pulse;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_sr_car_queue_counter.sv
// Testbench for sr_car_queue_counter: scenario tasks with inline checks
// against a run-length behavioural model of debounce, green timing and count.
module tb_sr_car_queue_counter;

    localparam int DEB  = 4;
    localparam int DEP  = 2;
    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       arrive_raw;
    logic [1:0] SR_ctl;
    logic       clr;
    logic [7:0] MR_cars;
    logic       arrive_pulse;
    logic       overflow;

    always #5 clk = ~clk;

    sr_car_queue_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPART_CYCLES  (DEP),
        .MAX_CARS       (MAXC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .arrive_raw  (arrive_raw),
        .SR_ctl      (SR_ctl),
        .clr         (clr),
        .MR_cars     (MR_cars),
        .arrive_pulse(arrive_pulse),
        .overflow    (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: sensor delay line, debounced level, run of disagreeing
    // samples, length of the current green phase, and the visible outputs
    logic m_d1, m_d2, m_level;
    int   m_run, m_green, m_cars;
    logic m_pulse, m_ovf, m_arr, m_dep;

    // One clock of stimulus followed by the model's view of that edge
    task automatic step(input logic r, input logic raw, input logic [1:0] sr, input logic c);
        logic smp;
        rst = r; arrive_raw = raw; SR_ctl = sr; clr = c;
        @(posedge clk);
        if (r) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_green = 0;
            m_cars = 0; m_pulse = 0; m_ovf = 0; m_arr = 0; m_dep = 0;
        end else begin
            smp = m_d2; m_d2 = m_d1; m_d1 = raw;
            m_arr = 0;
            if (smp == m_level) m_run = 0;
            else begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = smp; m_run = 0; m_arr = smp;
                end
            end
            m_dep = 0;
            if (sr != 2'b11) m_green = 0;
            else begin
                m_green++;
                if ((m_green % DEP) == 0 && m_cars > 0) m_dep = 1;
            end
            m_pulse = m_arr;
            if (c) begin m_cars = 0; m_ovf = 0; end
            else if (m_arr && m_dep) m_cars = m_cars;
            else if (m_arr) begin
                if (m_cars < MAXC) m_cars++; else m_ovf = 1;
            end else if (m_dep) m_cars--;
        end
        #1;
    endtask

    task automatic car(input logic [1:0] sr);
        repeat (6) step(0, 1, sr, 0);
        repeat (6) step(0, 0, sr, 0);
    endtask

    task automatic test_reset;
        logic [9:0] got, exp;
        repeat (3) begin
            step(1, 1, 2'b00, 0);
            got = {MR_cars, arrive_pulse, overflow}; exp = '0;
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL reset_state: got=%h expected=%h", got, exp); end
        end
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 2'b00, 0);
            got = {MR_cars, arrive_pulse, overflow};
            exp = {8'((k >= 7) ? 1 : 0), (k == 7), 1'b0};
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL reset_release k=%0d: got=%h expected=%h", k, got, exp); end
        end
        repeat (6) step(0, 0, 2'b00, 0);
    endtask

    task automatic test_single_arrival;
        logic [9:0] got, exp;
        repeat (2) step(1, 0, 2'b00, 0);
        for (int k = 1; k <= 20; k++) begin
            step(0, (k <= 10), 2'b00, 0);
            got = {MR_cars, arrive_pulse, overflow};
            exp = {8'((k >= 7) ? 1 : 0), (k == 7), 1'b0};
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL single_arrival k=%0d: got=%h expected=%h", k, got, exp); end
        end
    endtask

    task automatic test_glitch;
        logic [26:0] pat;
        logic [9:0]  got, exp;
        pat = 27'b111_000000_11101101011110_0000;
        repeat (2) step(1, 0, 2'b00, 0);
        for (int k = 26; k >= 0; k--) begin
            step(0, pat[k], 2'b00, 0);
            got = {MR_cars, arrive_pulse, overflow};
            exp = {8'(m_cars), m_pulse, m_ovf};
            checks++;
            if (got !== exp || got !== 10'd0) begin failures++;
                $display("FAIL glitch k=%0d: got=%h expected=%h", k, got, 10'd0); end
        end
        repeat (8) step(0, 0, 2'b00, 0);
        checks++;
        if (MR_cars !== 8'd0) begin failures++;
            $display("FAIL glitch_final: got=%0d expected=0", MR_cars); end
    endtask

    task automatic test_departures;
        logic [9:0] got, exp;
        repeat (2) step(1, 0, 2'b00, 0);
        repeat (50) car(2'b00);
        checks++;
        if (MR_cars !== 8'd50) begin failures++;
            $display("FAIL fifty_arrivals: got=%0d expected=50", MR_cars); end
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 2'b11, 0);
            got = {MR_cars, arrive_pulse, overflow};
            exp = {8'(m_cars), m_pulse, m_ovf};
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL green_drain k=%0d: got=%h expected=%h", k, got, exp); end
        end
        step(0, 0, 2'b00, 0);
        checks++;
        if (MR_cars !== 8'd45) begin failures++;
            $display("FAIL departures: got=%0d expected=45", MR_cars); end
    endtask

    task automatic test_saturation;
        logic [9:0] got;
        repeat (2) step(1, 0, 2'b00, 0);
        repeat (255) car(2'b00);
        got = {MR_cars, arrive_pulse, overflow};
        checks++;
        if (got !== {8'd255, 1'b0, 1'b0}) begin failures++;
            $display("FAIL at_max: got=%h expected=%h", got, {8'd255, 2'b00}); end
        car(2'b00);
        got = {MR_cars, arrive_pulse, overflow};
        checks++;
        if (got !== {8'd255, 1'b0, 1'b1}) begin failures++;
            $display("FAIL saturate: got=%h expected=%h", got, {8'd255, 2'b01}); end
        step(0, 0, 2'b00, 1);
        got = {MR_cars, arrive_pulse, overflow};
        checks++;
        if (got !== 10'd0) begin failures++;
            $display("FAIL clr: got=%h expected=000", got); end
        car(2'b00);
        got = {MR_cars, arrive_pulse, overflow};
        checks++;
        if (got !== {8'd1, 2'b00}) begin failures++;
            $display("FAIL after_clr: got=%h expected=%h", got, {8'd1, 2'b00}); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] got, exp;
        logic [1:0] sr;
        repeat (2) step(1, 0, 2'b00, 0);
        repeat (3) car(2'b00);
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 1; k <= 12; k++) begin
                sr = (k >= 5 + ph && k <= 7) ? 2'b11 : 2'b00;
                step(0, (k <= 6), sr, 0);
                got = {MR_cars, arrive_pulse, overflow};
                exp = {8'(m_cars), m_pulse, m_ovf};
                checks++;
                if (got !== exp) begin failures++;
                    $display("FAIL coincide ph=%0d k=%0d: got=%h expected=%h", ph, k, got, exp); end
                if (ph == 1 && k == 7) begin
                    checks++;
                    if (MR_cars !== 8'd3 || arrive_pulse !== 1'b1) begin failures++;
                        $display("FAIL coincide_hold: got=%0d/%0b expected=3/1", MR_cars, arrive_pulse); end
                end
            end
            checks++;
            if (MR_cars !== 8'd3) begin failures++;
                $display("FAIL coincide_end ph=%0d: got=%0d expected=3", ph, MR_cars); end
        end
        repeat (2) step(1, 0, 2'b00, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 2'b11, 0);
            checks++;
            if (MR_cars !== 8'd0 || overflow !== 1'b0) begin failures++;
                $display("FAIL green_at_zero k=%0d: got=%0d expected=0", k, MR_cars); end
        end
    endtask

    task automatic test_random;
        logic [9:0] got, exp;
        logic       raw, c, r;
        logic [1:0] sr;
        int         hold_raw, hold_sr;
        raw = 0; sr = 2'b00; hold_raw = 0; hold_sr = 0;
        step(1, 0, 2'b00, 0);
        for (int n = 0; n < 4000; n++) begin
            if (hold_raw == 0) begin raw = ~raw; hold_raw = $urandom_range(1, 9); end
            if (hold_sr == 0) begin
                sr = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                hold_sr = $urandom_range(1, 30);
            end
            hold_raw--; hold_sr--;
            c = ($urandom_range(0, 63) == 0);
            r = ($urandom_range(0, 799) == 0);
            step(r, raw, sr, c);
            got = {MR_cars, arrive_pulse, overflow};
            exp = {8'(m_cars), m_pulse, m_ovf};
            checks++;
            if (got !== exp) begin failures++;
                $display("FAIL random n=%0d: got=%h expected=%h", n, got, exp); end
        end
    endtask

    initial begin
        rst = 1'b1; arrive_raw = 1'b0; SR_ctl = 2'b00; clr = 1'b0;
        test_reset();
        test_single_arrival();
        test_glitch();
        test_departures();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
